fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer_if.sv | 25 ++
 rtl/fetch_sequencer.sv | 98 +++++++++
 tb/tb_fetch_sequencer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer, its ROM and its decoder.
// The slave side is the sequencer; the master side is the ROM/decoder environment.
interface fetch_sequencer_if;
  logic        run;
  logic        step;
  logic [7:0]  romData;
  logic        doJump;
  logic [7:0]  jumpTarget;
  logic        immUsed;
  logic [7:0]  pc;
  logic [7:0]  ir;
  logic        execute;
  logic        halted;
  logic [15:0] instrCount;

  modport master (
    output run, step, romData, doJump, jumpTarget, immUsed,
    input  pc, ir, execute, halted, instrCount
  );

  modport slave (
    input  run, step, romData, doJump, jumpTarget, immUsed,
    output pc, ir, execute, halted, instrCount
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Two-cycle FETCH/EXEC instruction sequencer with free-run, single-step and
// jump-to-self halt detection.
module fetch_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic             clk,
  input  logic             resetBar,
  fetch_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_pc;
  logic [7:0]  r_ir;
  logic [7:0]  r_instr_addr;
  logic [15:0] r_instr_count;
  logic        r_step_pending;
  logic        r_step_prev;
  logic        w_step_edge;
  logic        w_step_clear;
  logic        w_self_jump;

  assign w_step_edge = bus.step & ~r_step_prev;
  assign w_self_jump = bus.doJump && (bus.jumpTarget == r_instr_addr);

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_step_clear = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.run || r_step_pending) begin
          w_state_next = S_FETCH;
          w_step_clear = ~bus.run;
        end
      end
      S_FETCH: w_state_next = S_EXEC;
      S_EXEC: begin
        if (w_self_jump)  w_state_next = S_HALT;
        else if (bus.run) w_state_next = S_FETCH;
        else              w_state_next = S_IDLE;
      end
      S_HALT:  w_state_next = S_HALT;
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetBar) begin
    if (!resetBar) begin
      r_state        <= S_IDLE;
      r_pc           <= RESET_PC;
      r_ir           <= 8'h00;
      r_instr_addr   <= 8'h00;
      r_instr_count  <= 16'h0000;
      r_step_pending <= 1'b0;
      r_step_prev    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_step_prev <= bus.step;

      // Only one step is remembered; further edges while pending are dropped.
      if (w_step_clear)
        r_step_pending <= 1'b0;
      else if (w_step_edge && (r_state != S_HALT))
        r_step_pending <= 1'b1;

      case (r_state)
        S_FETCH: begin
          r_ir         <= bus.romData;
          r_instr_addr <= r_pc;
          r_pc         <= r_pc + 8'd1;
        end
        S_EXEC: begin
          if (bus.doJump)       r_pc <= bus.jumpTarget;
          else if (bus.immUsed) r_pc <= r_pc + 8'd1;
          r_instr_count <= r_instr_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.pc         = r_pc;
  assign bus.ir         = r_ir;
  assign bus.instrCount = r_instr_count;
  assign bus.execute    = (r_state == S_EXEC);
  assign bus.halted     = (r_state == S_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: instruction-level reference model,
// per-cycle compare, directed scenarios with literal expectations, random run.
module tb_fetch_sequencer;

  logic clk      = 1'b0;
  logic resetBar = 1'b1;

  fetch_sequencer_if bus ();

  fetch_sequencer #(.RESET_PC(8'h00)) dut (
    .clk      (clk),
    .resetBar (resetBar),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // ROM and decoder lookup tables, indexed by the DUT's own pc / ir.
  logic [7:0] rom      [256];
  logic       dec_jump [256];
  logic       dec_imm  [256];
  logic [7:0] dec_tgt  [256];

  assign bus.romData    = rom[bus.pc];
  assign bus.doJump     = dec_jump[bus.ir];
  assign bus.immUsed    = dec_imm[bus.ir];
  assign bus.jumpTarget = dec_tgt[bus.ir];

  int n_vec = 0;
  int n_err = 0;
  bit cmp_on = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one instruction = a fetch cycle then an exec cycle.
  // phase: 0 waiting for run/step, 1 fetching, 2 executing, 3 stopped for good.
  int          m_phase;
  logic [7:0]  m_pc, m_ir, m_addr;
  logic [15:0] m_cnt;
  bit          m_pend, m_prev;

  always @(posedge clk or negedge resetBar) begin
    bit edge_seen;
    bit old_pend;
    int old_phase;
    if (!resetBar) begin
      m_phase = 0; m_pc = 8'h00; m_ir = 8'h00; m_addr = 8'h00;
      m_cnt = 16'h0000; m_pend = 1'b0; m_prev = 1'b0;
    end else begin
      edge_seen = bus.step && !m_prev;
      m_prev    = bus.step;
      old_pend  = m_pend;
      old_phase = m_phase;
      if (m_phase == 0) begin
        if (bus.run || m_pend) begin
          if (!bus.run) m_pend = 1'b0;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_ir   = rom[m_pc];
        m_addr = m_pc;
        m_pc   = m_pc + 8'd1;
        m_phase = 2;
      end else if (m_phase == 2) begin
        m_cnt = m_cnt + 16'd1;
        if (dec_jump[m_ir]) begin
          m_phase = (dec_tgt[m_ir] == m_addr) ? 3 : (bus.run ? 1 : 0);
          m_pc = dec_tgt[m_ir];
        end else begin
          if (dec_imm[m_ir]) m_pc = m_pc + 8'd1;
          m_phase = bus.run ? 1 : 0;
        end
      end
      if (edge_seen && !old_pend && old_phase != 3) m_pend = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("pc",         bus.pc,         m_pc);
      check("ir",         bus.ir,         m_ir);
      check("instrCount", bus.instrCount, m_cnt);
      check("execute",    bus.execute,    m_phase == 2);
      check("halted",     bus.halted,     m_phase == 3);
    end
  end

  task automatic clear_tables();
    for (int i = 0; i < 256; i++) begin
      rom[i] = 8'h00; dec_jump[i] = 1'b0; dec_imm[i] = 1'b0; dec_tgt[i] = 8'h00;
    end
  endtask

  task automatic random_tables();
    for (int i = 0; i < 256; i++) begin
      rom[i]      = 8'($urandom);
      dec_jump[i] = ($urandom_range(0, 5) == 0);
      dec_imm[i]  = ($urandom_range(0, 2) == 0);
      dec_tgt[i]  = 8'($urandom);
    end
  endtask

  task automatic assert_reset();
    @(negedge clk);
    #2 resetBar = 1'b0;
    bus.run  = 1'b0;
    bus.step = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    @(negedge clk);
    resetBar = 1'b1;
  endtask

  task automatic wait_exec(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.execute && n < 50);
    check({tag, "_reached_exec"}, bus.execute, 1'b1);
  endtask

  initial begin
    bus.run  = 1'b0;
    bus.step = 1'b0;
    clear_tables();
    #2 resetBar = 1'b0;
    cmp_on = 1'b1;
    #1;
    check("reset_pc", bus.pc, 8'h00);
    check("reset_ir", bus.ir, 8'h00);
    check("reset_cnt", bus.instrCount, 16'h0000);
    check("reset_exec", bus.execute, 1'b0);
    check("reset_halt", bus.halted, 1'b0);
    release_reset();

    // Immediate-skipping instruction at address 0.
    assert_reset();
    clear_tables();
    rom[8'h00] = 8'h21; rom[8'h01] = 8'h05; dec_imm[8'h21] = 1'b1;
    release_reset();
    bus.run = 1'b1;
    wait_exec("imm");
    check("imm_ir", bus.ir, 8'h21);
    check("imm_pc_fetch", bus.pc, 8'h01);
    @(negedge clk);
    check("imm_pc_exec", bus.pc, 8'h02);
    check("imm_cnt", bus.instrCount, 16'd1);

    // Jump from 0x10 to 0x40, next fetch reads 0x40.
    assert_reset();
    clear_tables();
    rom[8'h00] = 8'hE1; dec_jump[8'hE1] = 1'b1; dec_tgt[8'hE1] = 8'h10;
    rom[8'h10] = 8'hE2; dec_jump[8'hE2] = 1'b1; dec_tgt[8'hE2] = 8'h40;
    rom[8'h40] = 8'h33;
    release_reset();
    bus.run = 1'b1;
    wait_exec("jmp0");
    wait_exec("jmp1");
    check("jmp_ir", bus.ir, 8'hE2);
    @(negedge clk);
    check("jmp_pc", bus.pc, 8'h40);
    check("jmp_halted", bus.halted, 1'b0);
    @(negedge clk);
    check("jmp_next_ir", bus.ir, 8'h33);
    check("jmp_next_pc", bus.pc, 8'h41);

    // Asynchronous reset in the middle of a jumping EXEC.
    assert_reset();
    clear_tables();
    rom[8'h00] = 8'hE1; dec_jump[8'hE1] = 1'b1; dec_tgt[8'hE1] = 8'h10;
    release_reset();
    bus.run = 1'b1;
    wait_exec("rst");
    #2 resetBar = 1'b0;
    #1;
    check("rst_async_pc", bus.pc, 8'h00);
    check("rst_async_ir", bus.ir, 8'h00);
    check("rst_async_exec", bus.execute, 1'b0);
    @(negedge clk);
    check("rst_pc", bus.pc, 8'h00);
    check("rst_cnt", bus.instrCount, 16'h0000);
    resetBar = 1'b1;

    // Jump-to-self halts and freezes everything.
    assert_reset();
    clear_tables();
    rom[8'h00] = 8'hE0; dec_jump[8'hE0] = 1'b1; dec_tgt[8'hE0] = 8'h07;
    rom[8'h07] = 8'hE7; dec_jump[8'hE7] = 1'b1; dec_tgt[8'hE7] = 8'h07;
    release_reset();
    bus.run = 1'b1;
    wait_exec("halt0");
    wait_exec("halt1");
    @(negedge clk);
    check("halt_flag", bus.halted, 1'b1);
    for (int i = 0; i < 20; i++) begin
      bus.run  = 1'($urandom);
      bus.step = 1'($urandom);
      @(negedge clk);
      check("halt_pc", bus.pc, 8'h07);
      check("halt_ir", bus.ir, 8'hE7);
      check("halt_cnt", bus.instrCount, 16'd2);
      check("halt_exec", bus.execute, 1'b0);
    end

    // Single stepping: two pulses, then a long held step.
    assert_reset();
    clear_tables();
    release_reset();
    for (int p = 0; p < 2; p++) begin
      bus.step = 1'b1;
      @(negedge clk);
      bus.step = 1'b0;
      repeat (10) @(negedge clk);
    end
    check("step_cnt2", bus.instrCount, 16'd2);
    check("step_pc2", bus.pc, 8'h02);
    check("step_idle", bus.execute, 1'b0);
    bus.step = 1'b1;
    repeat (10) @(negedge clk);
    bus.step = 1'b0;
    repeat (5) @(negedge clk);
    check("step_held_cnt", bus.instrCount, 16'd3);

    // pc wraps from 0xFF to 0x00 on fetch.
    assert_reset();
    clear_tables();
    rom[8'h00] = 8'hE3; dec_jump[8'hE3] = 1'b1; dec_tgt[8'hE3] = 8'hFF;
    release_reset();
    bus.run = 1'b1;
    wait_exec("wrap0");
    wait_exec("wrap1");
    check("wrap_pc", bus.pc, 8'h00);
    check("wrap_ir", bus.ir, 8'h00);

    // Randomised run/step/reset traffic against the model.
    assert_reset();
    random_tables();
    release_reset();
    begin
      int bias = 3;
      for (int c = 0; c < 3000; c++) begin
        @(negedge clk);
        if (c % 32 == 0) bias = $urandom_range(0, 4);
        if ($urandom_range(0, 199) == 0) begin
          #2 resetBar = 1'b0;
          @(negedge clk);
          resetBar = 1'b1;
        end
        bus.run  = ($urandom_range(0, 3) < bias);
        bus.step = ($urandom_range(0, 4) == 0);
      end
    end

    @(negedge clk);
    cmp_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
